gbus_p2s_unpack: RTL and testbench
==================================

# gbus_p2s_unpack

Parallel-to-serial unpacker on the core's activation/result path. It accepts packed GBUS words (lane i at bits `[i*IDATA_BIT +: IDATA_BIT]`, lane 0 first) and emits one IDATA_BIT element per cycle over a valid/ready stream. It is the mirror of the core's serial-to-parallel result packer and feeds per-element consumers such as the vector engine and quantization post-processing. Vector length is configurable, and the final word may be partially used: its unused upper lanes are discarded.

## Interface
Parameters:
- GBUS_DATA, 64, packed word width; must be an exact multiple of IDATA_BIT
- IDATA_BIT, 8, element width
- LEN_BIT, 12, width of the vector-length field
- Derived: REG_NUM = GBUS_DATA/IDATA_BIT; LANE_BIT = $clog2(REG_NUM)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches cfg_vec_len and begins a vector; ignored while busy
- cfg_vec_len  in  LEN_BIT  number of elements in the vector
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last element handshake
- idata  in  GBUS_DATA  packed input word
- idata_valid  in  1  input word valid
- idata_ready  out  1  unpacker accepts a word this cycle (registered)
- odata  out  IDATA_BIT  serial element
- odata_valid  out  1  element valid
- odata_last  out  1  qualifies the final element of the vector
- odata_ready  in  1  downstream accepts the element

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start with cfg_vec_len≠0 → LOAD.
  - start with cfg_vec_len=0 → DONE; no word is consumed.
- Latched at start: elem_rem = cfg_vec_len; word_rem = ceil(len/REG_NUM).
- LOAD: idata_ready=1. On an input handshake, capture the word into the shift register, set lane=0, decrement word_rem, and go to SHIFT.
- SHIFT:
  - odata = lane `lane` of the shift register.
  - On each output handshake: lane++ and elem_rem--.
  - When elem_rem reaches 1→0 → DONE.
  - When lane reaches REG_NUM-1 with elems remaining → next word (LOAD, or directly from the skid register; see Configuration).
- Partial last word: lanes at index ≥ (len mod REG_NUM) are never emitted.
- odata_last = odata_valid && elem_rem==1.
- Once word_rem==0, idata_ready stays low, so no surplus words are consumed.
- DONE: pulse done for one cycle, then go to IDLE.
- Output stability: while odata_valid && !odata_ready, odata and odata_last hold.
- start during busy: ignored; the latched length is unchanged.
- Reset (asynchronously, including mid-vector) clears the FSM to IDLE, all counters to 0, and any held skid word. A partially emitted vector is abandoned.

## Timing
- Reset values: idata_ready=0, odata=0, odata_valid=0, odata_last=0, busy=0, done=0.
- start at cycle t → busy=1 and idata_ready=1 at t+1.
- Input handshake at cycle t → first element valid at t+1.
- With odata_ready held high, a word's lanes come out on consecutive cycles.
- Word boundary without skid: one bubble cycle (LOAD) between the last lane of word n and lane 0 of word n+1.
- Last element handshake at cycle t → done=1 and busy=0 at t+1.
- len=0: start at cycle t → done at t+1.

## Configuration
- Macro: P2S_SKID_EN.
- Defined:
  - A one-entry holding register accepts the next word while SHIFT is active.
  - idata_ready = (holding register empty) && word_rem>0, registered.
  - On the last-lane handshake the held word moves straight into the shift register, so there are zero bubbles between words.
- Undefined:
  - No holding register; idata_ready is only high in LOAD.
  - One bubble per word boundary.
  - Smaller area.

## Structure
- Shared package core_pkg:
  - FSM state enum p2s_state_t (IDLE, LOAD, SHIFT, DONE)
  - GBUS_DATA and IDATA_BIT defaults
  - Elaboration check that GBUS_DATA % IDATA_BIT == 0
- Optional sub-module p2s_skid_reg: one-entry valid/data holding register, instantiated only under P2S_SKID_EN.

## Test plan
- Single word, len=8, odata_ready=1:
  - Stimulus: word 0x0807060504030201.
  - Response: odata 01..08 on 8 consecutive cycles; odata_last on 08; done the next cycle.
- Partial last word, len=10:
  - Stimulus: words 0x..0201, then 0x100F0E0D0C0B0A09.
  - Response: 10 elements, 01..08 then 09,0A. idata_ready is low after the second word and a third word offered is not consumed.
- Backpressure, len=8:
  - Stimulus: odata_ready alternating 1/0.
  - Response: every element is held stable while stalled; 8 elements in 15 cycles; no loss or duplication.
- Throughput, len=24, idata_valid constantly high:
  - With P2S_SKID_EN: 24 elements in 24 consecutive cycles.
  - Without: first-to-last element spans 26 cycles.
- len=0 and start-while-busy:
  - len=0 start → done next cycle with no input handshake.
  - A second start mid-vector is ignored; the original length completes.
- Reset mid-vector:
  - Stimulus: rstn low after 3 of 8 elements.
  - Response: all outputs return to reset values immediately; a new start with len=4 then works normally.

Source files
------------

// File: rtl/gbus_p2s_unpack_pkg.sv
// Shared types and defaults for the GBUS parallel-to-serial unpacker.
package gbus_p2s_unpack_pkg;

  localparam int GBUS_DATA_DEF = 64;
  localparam int IDATA_BIT_DEF = 8;
  localparam int LEN_BIT_DEF   = 12;

  // Unpacker control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } p2s_state_t;

  // Lane index width; never below 1 so a single-lane build still has a counter.
  function automatic int lane_bits(input int reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

endpackage

// File: rtl/gbus_p2s_unpack_if.sv
// Control, packed-input and serial-output bundle of the GBUS unpacker.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds valid and its payload
// stable until that edge; ready may change at any time and never waits on
// valid. idata_valid/idata_ready carry packed words into the unpacker and
// odata_valid/odata_ready carry elements (with odata_last) out of it.
interface gbus_p2s_unpack_if
  import gbus_p2s_unpack_pkg::*;
#(
  parameter int GBUS_DATA = GBUS_DATA_DEF,
  parameter int IDATA_BIT = IDATA_BIT_DEF,
  parameter int LEN_BIT   = LEN_BIT_DEF
) ();

  logic                 start;
  logic [LEN_BIT-1:0]   cfg_vec_len;
  logic                 busy;
  logic                 done;
  logic [GBUS_DATA-1:0] idata;
  logic                 idata_valid;
  logic                 idata_ready;
  logic [IDATA_BIT-1:0] odata;
  logic                 odata_valid;
  logic                 odata_last;
  logic                 odata_ready;
  p2s_state_t           state_dbg;

  // Unpacker side.
  modport slave (
    input  start, cfg_vec_len, idata, idata_valid, odata_ready,
    output busy, done, idata_ready, odata, odata_valid, odata_last, state_dbg
  );

  // Controller / producer / consumer side.
  modport master (
    output start, cfg_vec_len, idata, idata_valid, odata_ready,
    input  busy, done, idata_ready, odata, odata_valid, odata_last, state_dbg
  );

endinterface

// File: rtl/gbus_p2s_unpack_skid_reg.sv
// One-entry valid/data holding register used to prefetch the next packed word
// while the current one is being shifted out (only instantiated when
// P2S_SKID_EN is defined).
module p2s_skid_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Fill on push, drain on pop; a push wins over a same-cycle pop.
  always_comb begin
    valid_d = (valid_q && !pop_i) || push_i;
    data_d  = push_i ? push_data_i : data_q;
  end

  // Holding register; reset discards any held word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gbus_p2s_unpack.sv
// GBUS parallel-to-serial unpacker: takes packed words (lane 0 in the low
// bits, emitted first) and streams cfg_vec_len elements, discarding unused
// upper lanes of the final word.
// Build option: define P2S_SKID_EN to add a one-word holding register that
// removes the bubble cycle at every word boundary.
module gbus_p2s_unpack
  import gbus_p2s_unpack_pkg::*;
#(
  parameter int GBUS_DATA = GBUS_DATA_DEF,
  parameter int IDATA_BIT = IDATA_BIT_DEF,
  parameter int LEN_BIT   = LEN_BIT_DEF
) (
  input logic              clk,
  input logic              rstn,
  gbus_p2s_unpack_if.slave bus
);

  localparam int REG_NUM  = GBUS_DATA / IDATA_BIT;
  localparam int LANE_BIT = lane_bits(REG_NUM);

  localparam logic [LANE_BIT-1:0] LAST_LANE  = LANE_BIT'(REG_NUM - 1);
  localparam logic [LANE_BIT-1:0] ONE_LANE   = LANE_BIT'(1);
  localparam logic [LEN_BIT-1:0]  ONE_LEN    = LEN_BIT'(1);
  localparam logic [LEN_BIT:0]    REG_NUM_X  = (LEN_BIT + 1)'(REG_NUM);
  localparam logic [LEN_BIT:0]    REG_NUM_M1 = (LEN_BIT + 1)'(REG_NUM - 1);

  if (GBUS_DATA % IDATA_BIT != 0) begin : g_width_check
    $error("GBUS_DATA must be an exact multiple of IDATA_BIT");
  end

  p2s_state_t           state_q, state_d;
  logic [LEN_BIT-1:0]   elem_rem_q, elem_rem_d;
  logic [LEN_BIT-1:0]   word_rem_q, word_rem_d;
  logic [LANE_BIT-1:0]  lane_q, lane_d;
  logic [GBUS_DATA-1:0] shreg_q, shreg_d;
  logic                 idata_ready_q, idata_ready_d;
  logic [IDATA_BIT-1:0] odata_q, odata_d;
  logic                 odata_valid_q, odata_valid_d;
  logic                 odata_last_q, odata_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LEN_BIT:0]     len_ext;
  logic                 in_hs;
  logic                 out_hs;

  assign in_hs  = bus.idata_valid && idata_ready_q;
  assign out_hs = odata_valid_q && bus.odata_ready;

`ifdef P2S_SKID_EN
  logic                 skid_push;
  logic                 skid_pop;
  logic                 take_direct;
  logic                 skid_valid_q;
  logic                 skid_valid_nx;
  logic [GBUS_DATA-1:0] skid_data_q;

  p2s_skid_reg #(.W(GBUS_DATA)) u_skid (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (skid_push),
    .push_data_i (bus.idata),
    .pop_i       (skid_pop),
    .valid_o     (skid_valid_q),
    .data_o      (skid_data_q)
  );
`endif

  // Next-state, counters, shift register and the registered output values.
  always_comb begin
    state_d    = state_q;
    elem_rem_d = elem_rem_q;
    word_rem_d = word_rem_q;
    lane_d     = lane_q;
    shreg_d    = shreg_q;
`ifdef P2S_SKID_EN
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    take_direct = 1'b0;
`endif
    // Words needed = ceil(len / REG_NUM), computed one bit wider so the
    // rounding add cannot wrap.
    len_ext = {1'b0, bus.cfg_vec_len} + REG_NUM_M1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          elem_rem_d = bus.cfg_vec_len;
          word_rem_d = LEN_BIT'(len_ext / REG_NUM_X);
          lane_d     = '0;
          state_d    = (bus.cfg_vec_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_hs) begin
          shreg_d    = bus.idata;
          lane_d     = '0;
          word_rem_d = word_rem_q - ONE_LEN;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (out_hs) begin
          if (elem_rem_q == ONE_LEN) begin
            // Last element; unused upper lanes of this word are dropped.
            elem_rem_d = '0;
            state_d    = DONE;
          end else begin
            elem_rem_d = elem_rem_q - ONE_LEN;
            if (lane_q == LAST_LANE) begin
              lane_d = '0;
`ifdef P2S_SKID_EN
              if (skid_valid_q) begin
                shreg_d  = skid_data_q;
                skid_pop = 1'b1;
              end else if (in_hs) begin
                // Word arriving exactly at the boundary bypasses the skid.
                shreg_d     = bus.idata;
                take_direct = 1'b1;
              end else begin
                state_d = LOAD;
              end
`else
              state_d = LOAD;
`endif
            end else begin
              lane_d = lane_q + ONE_LANE;
            end
          end
        end
`ifdef P2S_SKID_EN
        if (in_hs) begin
          word_rem_d = word_rem_q - ONE_LEN;
          skid_push  = !take_direct;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d        = (state_d == LOAD) || (state_d == SHIFT);
    done_d        = (state_d == DONE);
    odata_valid_d = (state_d == SHIFT);
    odata_last_d  = (state_d == SHIFT) && (elem_rem_d == ONE_LEN);
    odata_d       = (state_d == SHIFT) ? shreg_d[int'(lane_d)*IDATA_BIT +: IDATA_BIT] : '0;

`ifdef P2S_SKID_EN
    skid_valid_nx = (skid_valid_q && !skid_pop) || skid_push;
    idata_ready_d = busy_d && !skid_valid_nx && (word_rem_d != '0);
`else
    idata_ready_d = (state_d == LOAD) && (word_rem_d != '0);
`endif
  end

  // All state and outputs are flops; reset abandons any vector in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      elem_rem_q    <= '0;
      word_rem_q    <= '0;
      lane_q        <= '0;
      shreg_q       <= '0;
      idata_ready_q <= 1'b0;
      odata_q       <= '0;
      odata_valid_q <= 1'b0;
      odata_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      elem_rem_q    <= elem_rem_d;
      word_rem_q    <= word_rem_d;
      lane_q        <= lane_d;
      shreg_q       <= shreg_d;
      idata_ready_q <= idata_ready_d;
      odata_q       <= odata_d;
      odata_valid_q <= odata_valid_d;
      odata_last_q  <= odata_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.idata_ready = idata_ready_q;
  assign bus.odata       = odata_q;
  assign bus.odata_valid = odata_valid_q;
  assign bus.odata_last  = odata_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_gbus_p2s_unpack.sv
// Self-checking bench for gbus_p2s_unpack (works with or without P2S_SKID_EN).
module tb_gbus_p2s_unpack;
  import gbus_p2s_unpack_pkg::*;

  localparam int GBUS_DATA = 64;
  localparam int IDATA_BIT = 8;
  localparam int LEN_BIT   = 12;
  localparam int REG_NUM   = GBUS_DATA / IDATA_BIT;
`ifdef P2S_SKID_EN
  localparam int SPAN24 = 23;
`else
  localparam int SPAN24 = 25;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gbus_p2s_unpack_if #(.GBUS_DATA(GBUS_DATA), .IDATA_BIT(IDATA_BIT), .LEN_BIT(LEN_BIT)) bus ();

  gbus_p2s_unpack #(.GBUS_DATA(GBUS_DATA), .IDATA_BIT(IDATA_BIT), .LEN_BIT(LEN_BIT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [IDATA_BIT:0]   exp_q[$];   // {last, data}
  logic [GBUS_DATA-1:0] word_q[$];
  int n_checks = 0;
  int n_fails  = 0;
  int ready_mode = 0;               // 0 always, 1 alternate, 2 random
  int elem_cnt, in_cnt, first_in_cyc, first_elem_cyc, last_elem_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- input word driver + output ready driver ----------------
  initial begin : drive_proc
    logic in_pend;
    bus.idata_valid = 1'b0;
    bus.idata       = '0;
    bus.odata_ready = 1'b0;
    forever begin
      @(negedge clk);
      in_pend = bus.idata_valid && bus.idata_ready;
      if (in_pend && first_in_cyc < 0) first_in_cyc = cyc;
      @(posedge clk);
      #1;
      if (in_pend && word_q.size() > 0) begin
        void'(word_q.pop_front());
        in_cnt++;
      end
      bus.idata_valid = (word_q.size() > 0);
      bus.idata       = (word_q.size() > 0) ? word_q[0] : '0;
      case (ready_mode)
        1:       bus.odata_ready = cyc[0];
        2:       bus.odata_ready = 1'($urandom_range(0, 1));
        default: bus.odata_ready = 1'b1;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin : mon_proc
    logic [IDATA_BIT:0] e;
    forever begin
      @(negedge clk);
      if (rstn && bus.odata_valid) begin
        check_eq("elem_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          if (bus.odata_ready) begin
            void'(exp_q.pop_front());
            check_eq("odata", bus.odata, e[IDATA_BIT-1:0]);
            check_eq("odata_last", bus.odata_last, e[IDATA_BIT]);
            elem_cnt++;
            if (first_elem_cyc < 0) first_elem_cyc = cyc;
            last_elem_cyc = cyc;
          end else begin
            check_eq("odata_hold", bus.odata, e[IDATA_BIT-1:0]);
            check_eq("odata_last_hold", bus.odata_last, e[IDATA_BIT]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_stats();
    elem_cnt = 0; in_cnt = 0;
    first_in_cyc = -1; first_elem_cyc = -1; last_elem_cyc = -1;
  endtask

  // Build the packed words for a vector and the expected element stream.
  task automatic queue_vec(input int len, input int extra, input int seed);
    logic [GBUS_DATA-1:0] w;
    logic [IDATA_BIT-1:0] b;
    int nw;
    nw = (len + REG_NUM - 1) / REG_NUM + extra;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int l = 0; l < REG_NUM; l++) begin
        b = IDATA_BIT'(seed + wi * REG_NUM + l);
        w[l*IDATA_BIT +: IDATA_BIT] = b;
        if (wi * REG_NUM + l < len) exp_q.push_back({(wi * REG_NUM + l == len - 1), b});
      end
      word_q.push_back(w);
    end
  endtask

  task automatic start_vec(input int len);
    bus.cfg_vec_len = LEN_BIT'(len);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    if (len == 0) begin
      check_eq("len0_done", bus.done, 1);
      check_eq("len0_busy", bus.busy, 0);
    end else begin
      check_eq("start_busy", bus.busy, 1);
      check_eq("start_ready", bus.idata_ready, 1);
    end
  endtask

  task automatic wait_elems(input int n, input int budget);
    int i;
    for (i = 0; i < budget && elem_cnt < n; i++) next_cycle();
    check_eq("elem_wait", elem_cnt >= n, 1);
  endtask

  // Wait for done, check its timing and the pulse width, then settle in IDLE.
  task automatic wait_done(input int len, input int budget);
    logic seen;
    int done_cyc;
    seen = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end else begin
        next_cycle();
      end
    end
    check_eq("done_seen", seen, 1);
    if (seen) begin
      check_eq("done_busy", bus.busy, 0);
      check_eq("done_latency", done_cyc - last_elem_cyc, 1);
      check_eq("exp_drained", exp_q.size(), 0);
      check_eq("elem_count", elem_cnt, len);
      next_cycle();
      check_eq("done_pulse", bus.done, 0);
      check_eq("idle_state", bus.state_dbg, IDLE);
    end
  endtask

  task automatic run_vec(input int len, input int extra, input int seed, input int mode);
    reset_stats();
    ready_mode = mode;
    queue_vec(len, extra, seed);
    start_vec(len);
    wait_done(len, 2000);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_proc
    bus.start = 1'b0;
    bus.cfg_vec_len = '0;
    reset_stats();
    repeat (3) next_cycle();
    check_eq("rst_idata_ready", bus.idata_ready, 0);
    check_eq("rst_odata", bus.odata, 0);
    check_eq("rst_odata_valid", bus.odata_valid, 0);
    check_eq("rst_odata_last", bus.odata_last, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    rstn = 1'b1;
    repeat (2) next_cycle();

    // Single word, full throughput.
    run_vec(8, 0, 1, 0);
    check_eq("t1_first_latency", first_elem_cyc - first_in_cyc, 1);
    check_eq("t1_span", last_elem_cyc - first_elem_cyc, 7);

    // Partial last word with a surplus word offered.
    run_vec(10, 1, 1, 0);
    check_eq("t2_words_taken", in_cnt, 2);
    check_eq("t2_surplus_left", word_q.size(), 1);
    check_eq("t2_ready_low", bus.idata_ready, 0);
    repeat (3) next_cycle();
    check_eq("t2_surplus_still", word_q.size(), 1);
    word_q.delete();
    repeat (2) next_cycle();

    // Alternating backpressure.
    run_vec(8, 0, 8'h21, 1);
    check_eq("t3_span", last_elem_cyc - first_elem_cyc, 14);

    // Throughput across word boundaries.
    run_vec(24, 0, 8'h30, 0);
    check_eq("t4_span", last_elem_cyc - first_elem_cyc, SPAN24);

    // Zero length: done without consuming input.
    reset_stats();
    ready_mode = 0;
    start_vec(0);
    next_cycle();
    check_eq("t5_no_word", in_cnt, 0);
    check_eq("t5_done_pulse", bus.done, 0);
    next_cycle();

    // Start while busy is ignored.
    reset_stats();
    queue_vec(16, 0, 8'h40);
    start_vec(16);
    wait_elems(2, 200);
    bus.cfg_vec_len = LEN_BIT'(3);
    bus.start = 1'b1;
    next_cycle();
    bus.start = 1'b0;
    check_eq("t6_still_busy", bus.busy, 1);
    wait_done(16, 2000);

    // Reset mid-vector, then a clean short vector.
    reset_stats();
    queue_vec(8, 0, 8'h80);
    start_vec(8);
    wait_elems(3, 200);
    rstn = 1'b0;
    #1;
    check_eq("mr_idata_ready", bus.idata_ready, 0);
    check_eq("mr_odata", bus.odata, 0);
    check_eq("mr_odata_valid", bus.odata_valid, 0);
    check_eq("mr_odata_last", bus.odata_last, 0);
    check_eq("mr_busy", bus.busy, 0);
    check_eq("mr_done", bus.done, 0);
    check_eq("mr_state", bus.state_dbg, IDLE);
    exp_q.delete();
    word_q.delete();
    next_cycle();
    rstn = 1'b1;
    repeat (2) next_cycle();
    run_vec(4, 0, 8'hA0, 0);

    // Random lengths under random backpressure.
    for (int k = 0; k < 4; k++) begin
      run_vec(int'($urandom_range(1, 30)), 0, int'($urandom_range(0, 255)), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
